// File: rtl/msf_pkg.sv
// Shared constants and helpers for MSF minute-frame checking.
// Second indices refer to the position within the minute, with the marker as second 00.
package msf_pkg;

  localparam int unsigned PAR_YEAR_LO   = 17;
  localparam int unsigned PAR_YEAR_HI   = 24;
  localparam int unsigned PAR_DATE_LO   = 25;
  localparam int unsigned PAR_DATE_HI   = 35;
  localparam int unsigned PAR_DOW_LO    = 36;
  localparam int unsigned PAR_DOW_HI    = 38;
  localparam int unsigned PAR_TIME_LO   = 39;
  localparam int unsigned PAR_TIME_HI   = 51;
  localparam int unsigned PAR_BIT_BASE  = 54;
  localparam int unsigned MARKER_LO     = 52;
  localparam int unsigned MARKER_HI     = 59;
  localparam int unsigned FRAME_SECONDS = 60;

  // Bit 7 is second 52, bit 0 is second 59.
  localparam logic [7:0] MARKER_PATTERN = 8'b01111110;

  localparam int unsigned ERR_LEN      = 0;
  localparam int unsigned ERR_MARKER   = 1;
  localparam int unsigned ERR_PAR_YEAR = 2;
  localparam int unsigned ERR_PAR_DATE = 3;
  localparam int unsigned ERR_PAR_DOW  = 4;
  localparam int unsigned ERR_PAR_TIME = 5;

  typedef enum logic {StHunt, StRun} state_e;

  function automatic logic in_range(logic [5:0] s, int unsigned lo, int unsigned hi);
    return ({26'd0, s} >= lo) && ({26'd0, s} <= hi);
  endfunction

  function automatic logic marker_bit(logic [5:0] s);
    logic [2:0] idx;
    idx = 3'(s - 6'(MARKER_LO));
    return MARKER_PATTERN[3'd7 - idx];
  endfunction

endpackage

// File: rtl/msf_frame_checker.sv
// Checks MSF minute frames for length, minute-identifier pattern and odd parity,
// producing a per-frame verdict pulse and a lock flag after consecutive good frames.
module msf_frame_checker
  import msf_pkg::*;
#(
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       bits_valid_i,
  input  logic       bits_is_second_00_i,
  input  logic [1:0] bits_data_i,
  output logic       frame_valid_o,
  output logic       frame_ok_o,
  output logic [5:0] err_o,
  output logic       lock_o
);

  state_e     state_q, state_d;
  logic [5:0] sec_q, sec_d, sec_inc;
  logic [3:0] par_q, par_d;  // [0] year, [1] date, [2] dow, [3] time
  logic       mark_err_q, mark_err_d;
  logic [3:0] good_q, good_d;
  logic       fv_q, ok_q, lock_q;
  logic [5:0] err_q, verdict;
  logic       marker, data_strobe, frame_end;
  logic [1:0] pidx;

  assign marker = bits_valid_i && bits_is_second_00_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= StHunt;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StHunt:  if (marker) state_d = StRun;
      StRun:   state_d = StRun;
      default: state_d = StHunt;
    endcase
  end

  always_comb begin
    data_strobe = (state_q == StRun) && bits_valid_i && !bits_is_second_00_i;
    frame_end   = (state_q == StRun) && marker;
  end

  always_comb begin
    sec_inc    = (sec_q == 6'd63) ? sec_q : sec_q + 6'd1;
    pidx       = 2'(sec_inc - 6'(PAR_BIT_BASE));
    sec_d      = sec_q;
    par_d      = par_q;
    mark_err_d = mark_err_q;
    if (marker) begin
      sec_d      = '0;
      par_d      = '0;
      mark_err_d = 1'b0;
    end else if (data_strobe) begin
      sec_d = sec_inc;
      if (in_range(sec_inc, PAR_YEAR_LO, PAR_YEAR_HI)) par_d[0] = par_d[0] ^ bits_data_i[0];
      if (in_range(sec_inc, PAR_DATE_LO, PAR_DATE_HI)) par_d[1] = par_d[1] ^ bits_data_i[0];
      if (in_range(sec_inc, PAR_DOW_LO, PAR_DOW_HI))   par_d[2] = par_d[2] ^ bits_data_i[0];
      if (in_range(sec_inc, PAR_TIME_LO, PAR_TIME_HI)) par_d[3] = par_d[3] ^ bits_data_i[0];
      if (in_range(sec_inc, PAR_BIT_BASE, PAR_BIT_BASE + 3)) begin
        par_d[pidx] = par_d[pidx] ^ bits_data_i[1];
      end
      if (in_range(sec_inc, MARKER_LO, MARKER_HI) && (bits_data_i[0] != marker_bit(sec_inc))) begin
        mark_err_d = 1'b1;
      end
    end
  end

  // Parity is odd, so an accumulator left at zero means the check failed.
  always_comb begin
    verdict               = '0;
    verdict[ERR_LEN]      = (sec_q != 6'(FRAME_SECONDS - 1));
    verdict[ERR_MARKER]   = mark_err_q;
    verdict[ERR_PAR_YEAR] = ~par_q[0];
    verdict[ERR_PAR_DATE] = ~par_q[1];
    verdict[ERR_PAR_DOW]  = ~par_q[2];
    verdict[ERR_PAR_TIME] = ~par_q[3];
    good_d = good_q;
    if (frame_end) begin
      if (verdict != '0)                    good_d = '0;
      else if (good_q != 4'(LOCK_FRAMES))   good_d = good_q + 4'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sec_q      <= '0;
      par_q      <= '0;
      mark_err_q <= 1'b0;
      good_q     <= '0;
      fv_q       <= 1'b0;
      ok_q       <= 1'b0;
      err_q      <= '0;
      lock_q     <= 1'b0;
    end else begin
      sec_q      <= sec_d;
      par_q      <= par_d;
      mark_err_q <= mark_err_d;
      good_q     <= good_d;
      fv_q       <= frame_end;
      if (frame_end) begin
        ok_q   <= (verdict == '0);
        err_q  <= verdict;
        lock_q <= (good_d == 4'(LOCK_FRAMES));
      end
    end
  end

  assign frame_valid_o = fv_q;
  assign frame_ok_o    = ok_q;
  assign err_o         = err_q;
  assign lock_o        = lock_q;

endmodule

// File: tb/tb_msf_frame_checker.sv
// Directed and randomized frames checked against a per-frame reference model.
module tb_msf_frame_checker;

  localparam int unsigned LOCK = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       bits_valid = 1'b0;
  logic       is00 = 1'b0;
  logic [1:0] data = 2'b00;
  logic       frame_valid, frame_ok, lock;
  logic [5:0] err;

  msf_frame_checker #(.LOCK_FRAMES(LOCK)) dut (
    .clk_i               (clk),
    .rst_i               (rst),
    .bits_valid_i        (bits_valid),
    .bits_is_second_00_i (is00),
    .bits_data_i         (data),
    .frame_valid_o       (frame_valid),
    .frame_ok_o          (frame_ok),
    .err_o               (err),
    .lock_o              (lock)
  );

  always #5 clk = ~clk;

  int total = 0;
  int passed = 0;

  // Frame to transmit, indexed by second.
  bit fa[0:63];
  bit fb[0:63];

  // Reference model state.
  bit         running;
  int         cnt;
  bit         ma[0:63];
  bit         mb[0:63];
  int unsigned good;
  bit         exp_fv, exp_ok, exp_lock;
  logic [5:0] exp_err;

  task automatic check(input string tag, input logic [5:0] got, input logic [5:0] expv);
    total++;
    assert (got === expv) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, expv);
  endtask

  task automatic model_verdict();
    int lo[4] = '{17, 25, 36, 39};
    int hi[4] = '{24, 35, 38, 51};
    logic [5:0] e = '0;
    e[0] = (cnt != 59);
    for (int s = 52; s <= 59; s++) begin
      bit want = (s > 52 && s < 59);
      if (s <= cnt && ma[s] != want) e[1] = 1'b1;
    end
    for (int k = 0; k < 4; k++) begin
      bit x = mb[54 + k];
      for (int s = lo[k]; s <= hi[k]; s++) x ^= ma[s];
      e[2 + k] = (x == 1'b0);
    end
    exp_err = e;
    exp_ok  = (e == '0);
    if (!exp_ok)         good = 0;
    else if (good < LOCK) good = good + 1;
    exp_lock = (good == LOCK);
  endtask

  task automatic model_step(input bit mk, input bit a, input bit b);
    exp_fv = 1'b0;
    if (mk) begin
      if (running) begin
        model_verdict();
        exp_fv = 1'b1;
      end
      running = 1'b1;
      cnt = 0;
      for (int s = 0; s < 64; s++) begin
        ma[s] = 1'b0;
        mb[s] = 1'b0;
      end
    end else if (running) begin
      if (cnt < 63) cnt++;
      ma[cnt] = a;
      mb[cnt] = b;
    end
  endtask

  task automatic send(input bit mk, input bit a, input bit b);
    @(negedge clk);
    bits_valid = 1'b1;
    is00 = mk;
    data = {b, a};
    model_step(mk, a, b);
    @(negedge clk);
    bits_valid = 1'b0;
    is00 = 1'b0;
    check("frame_valid", 6'(frame_valid), 6'(exp_fv));
    check("frame_ok", 6'(frame_ok), 6'(exp_ok));
    check("err", err, exp_err);
    check("lock", 6'(lock), 6'(exp_lock));
    @(negedge clk);
    check("frame_valid_pulse_end", 6'(frame_valid), 6'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bits_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    running = 1'b0;
    good = 0;
    exp_fv = 1'b0;
    exp_ok = 1'b0;
    exp_err = '0;
    exp_lock = 1'b0;
    check("rst_frame_valid", 6'(frame_valid), 6'd0);
    check("rst_frame_ok", 6'(frame_ok), 6'd0);
    check("rst_err", err, 6'd0);
    check("rst_lock", 6'(lock), 6'd0);
  endtask

  function automatic int bcd(input int v);
    return (v / 10) * 16 + (v % 10);
  endfunction

  task automatic put(input int lo, input int width, input int value);
    for (int i = 0; i < width; i++) fa[lo + i] = value[width - 1 - i];
  endtask

  task automatic build(input int yr, input int mo, input int dy, input int dw,
                       input int hr, input int mn);
    int lo[4] = '{17, 25, 36, 39};
    int hi[4] = '{24, 35, 38, 51};
    for (int s = 0; s < 64; s++) begin
      fa[s] = 1'($urandom);
      fb[s] = 1'($urandom);
    end
    put(17, 8, bcd(yr));
    put(25, 5, bcd(mo));
    put(30, 6, bcd(dy));
    put(36, 3, dw);
    put(39, 6, bcd(hr));
    put(45, 7, bcd(mn));
    fa[52] = 1'b0;
    for (int s = 53; s <= 58; s++) fa[s] = 1'b1;
    fa[59] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bit x = 1'b0;
      for (int s = lo[k]; s <= hi[k]; s++) x ^= fa[s];
      fb[54 + k] = ~x;
    end
  endtask

  task automatic build_ref();
    build(23, 3, 15, 3, 12, 34);
  endtask

  // Data seconds 1..n, then the marker that closes the frame.
  task automatic send_frame(input int n);
    for (int s = 1; s <= n; s++) begin
      if (s < 60) send(1'b0, fa[s], fb[s]);
      else        send(1'b0, 1'($urandom), 1'($urandom));
    end
    send(1'b1, 1'b1, 1'b0);
  endtask

  initial begin
    running = 1'b0;
    good = 0;
    do_reset();

    // Traffic before any marker, including a whole fake frame, must be ignored.
    for (int i = 0; i < 10; i++) send(1'b0, 1'($urandom), 1'($urandom));
    build_ref();
    for (int s = 1; s <= 59; s++) send(1'b0, fa[s], fb[s]);
    send(1'b1, 1'b1, 1'b0);

    // Two good frames lock, a bad 57B drops it.
    send_frame(59);
    send_frame(59);
    fb[57] = ~fb[57];
    send_frame(59);
    build_ref();

    // Length errors: short and long (saturating) frames.
    send_frame(58);
    send_frame(70);

    // Marker pattern and individual parity bits.
    fa[52] = 1'b1;
    send_frame(59);
    build_ref();
    for (int k = 54; k <= 56; k++) begin
      fb[k] = ~fb[k];
      send_frame(59);
      build_ref();
    end

    // Reset mid-frame abandons it; the next marker only opens a frame.
    send_frame(59);
    for (int s = 1; s <= 30; s++) send(1'b0, fa[s], fb[s]);
    do_reset();
    send(1'b1, 1'b1, 1'b0);
    send_frame(59);

    // Randomized frames with occasional corruption.
    for (int i = 0; i < 30; i++) begin
      int mode = int'($urandom_range(0, 5));
      build(int'($urandom_range(0, 99)), int'($urandom_range(1, 12)),
            int'($urandom_range(1, 31)), int'($urandom_range(0, 6)),
            int'($urandom_range(0, 23)), int'($urandom_range(0, 59)));
      if (mode == 0) begin
        int p = int'($urandom_range(17, 59));
        fa[p] = ~fa[p];
        send_frame(59);
      end else if (mode == 1) begin
        int p = int'($urandom_range(54, 57));
        fb[p] = ~fb[p];
        send_frame(59);
      end else if (mode == 2) begin
        send_frame(int'($urandom_range(57, 61)));
      end else begin
        send_frame(59);
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
